// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_pkg;

  localparam int unsigned PC_XLEN_DEFAULT = 32'd32;
  localparam int unsigned PC_INCR         = 32'd4;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_sequencer_next_sel.sv
// Fixed-priority next-PC mux: trap, then redirect, then sequential increment.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = PC_XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            req_en_i,
  input  logic            incr_en_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vector_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            misaligned_o,
  output logic            incr_o
);

  // Low address bits are forced to zero on load; only redirects report them.
  always_comb begin
    pc_next_o    = pc_i;
    misaligned_o = 1'b0;
    incr_o       = 1'b0;
    if (req_en_i && trap_valid_i) begin
      pc_next_o = {trap_vector_i[XLEN-1:2], 2'b00};
    end else if (req_en_i && redirect_valid_i) begin
      pc_next_o    = {redirect_target_i[XLEN-1:2], 2'b00};
      misaligned_o = |redirect_target_i[1:0];
    end else if (incr_en_i) begin
      pc_next_o = pc_i + XLEN'(PC_INCR);
      incr_o    = 1'b1;
    end else begin
      pc_next_o = pc_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with BOOT/RUN/HALT control and prioritised redirects.
// Optional fetch counter is built when PC_FETCH_COUNTER_EN is defined.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = PC_XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     CNT_WIDTH    = 32'd32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_ready,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_target,
  input  logic                 trap_valid,
  input  logic [XLEN-1:0]      trap_vector,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      pcplus4,
  output logic                 pc_valid,
  output logic                 halted,
`ifdef PC_FETCH_COUNTER_EN
  output logic [CNT_WIDTH-1:0] fetch_count,
`endif
  output logic                 misaligned
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            halted_q, halted_d;
  logic            misaligned_q, misaligned_d;
  logic            req_en_s, incr_en_s, incr_s;

  // Requests are ignored during the BOOT bubble; a pending halt blocks increment.
  assign req_en_s  = (state_q != PC_BOOT);
  assign incr_en_s = (state_q == PC_RUN) & pc_valid_q & fetch_ready & ~stall & ~halt_req;

  pc_next_sel #(.XLEN(XLEN)) u_next_sel (
    .pc_i              (pc_q),
    .req_en_i          (req_en_s),
    .incr_en_i         (incr_en_s),
    .trap_valid_i      (trap_valid),
    .trap_vector_i     (trap_vector),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .pc_next_o         (pc_d),
    .misaligned_o      (misaligned_d),
    .incr_o            (incr_s)
  );

  // Control FSM next state; valid/halted flags follow the destination state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PC_BOOT: state_d = PC_RUN;
      PC_RUN: begin
        if (halt_req) state_d = PC_HALT;
        else          state_d = PC_RUN;
      end
      PC_HALT: begin
        if (resume && !halt_req) state_d = PC_RUN;
        else                     state_d = PC_HALT;
      end
      default: state_d = PC_BOOT;
    endcase
    pc_valid_d = (state_d == PC_RUN);
    halted_d   = (state_d == PC_HALT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PC_BOOT;
      pc_q         <= RESET_VECTOR;
      pc_valid_q   <= 1'b0;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc         = pc_q;
  assign pcplus4    = pc_q + XLEN'(PC_INCR);
  assign pc_valid   = pc_valid_q;
  assign halted     = halted_q;
  assign misaligned = misaligned_q;

`ifdef PC_FETCH_COUNTER_EN
  logic [CNT_WIDTH-1:0] fetch_count_q;

  // Counts only accepted fetches that advanced the PC sequentially.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else if (incr_s) begin
      fetch_count_q <= fetch_count_q + CNT_WIDTH'(1);
    end else begin
      fetch_count_q <= fetch_count_q;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  logic unused_incr_s;
  assign unused_incr_s = incr_s;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_ready = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vector = 32'h0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc, pcplus4;
  logic        pc_valid, halted, misaligned;
`ifdef PC_FETCH_COUNTER_EN
  logic [31:0] fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .CNT_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_ready     (fetch_ready),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc              (pc),
    .pcplus4         (pcplus4),
    .pc_valid        (pc_valid),
    .halted          (halted),
`ifdef PC_FETCH_COUNTER_EN
    .fetch_count     (fetch_count),
`endif
    .misaligned      (misaligned)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fetch_ready = 1'b1;
    step();
    step();
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b0 || halted !== 1'b0 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h valid=%b halted=%b mis=%b, need 0/0/0/0", pc, pc_valid, halted, misaligned);
    end
    rst = 1'b0;
    checks++;
    if (pc_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_bubble: pc_valid=%b, need 0", pc_valid);
    end
    step();
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_fetch: pc=%h valid=%b, need 00000000/1", pc, pc_valid);
    end
    step();
    checks++;
    if (pc !== 32'h4) begin
      errors++;
      $display("FAIL seq_4: pc=%h, need 00000004", pc);
    end
    step();
    checks++;
    if (pc !== 32'h8 || pcplus4 !== 32'hC) begin
      errors++;
      $display("FAIL seq_8: pc=%h pcplus4=%h, need 00000008/0000000c", pc, pcplus4);
    end
  endtask

  task automatic test_stall();
    step();
    step();
    checks++;
    if (pc !== 32'h10) begin
      errors++;
      $display("FAIL reach_10: pc=%h, need 00000010", pc);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc !== 32'h10) begin
        errors++;
        $display("FAIL stall_hold_%0d: pc=%h, need 00000010", i, pc);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (pc !== 32'h14) begin
      errors++;
      $display("FAIL stall_release: pc=%h, need 00000014", pc);
    end
    fetch_ready = 1'b0;
    step();
    checks++;
    if (pc !== 32'h14) begin
      errors++;
      $display("FAIL not_ready_hold: pc=%h, need 00000014", pc);
    end
    fetch_ready = 1'b1;
  endtask

  task automatic test_priority();
    trap_valid = 1'b1;
    trap_vector = 32'h0000_0103;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0200;
    step();
    checks++;
    if (pc !== 32'h100 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL trap_over_redirect: pc=%h mis=%b, need 00000100/0", pc, misaligned);
    end
    trap_valid = 1'b0;
    redirect_target = 32'h0000_0202;
    step();
    checks++;
    if (pc !== 32'h200 || misaligned !== 1'b1) begin
      errors++;
      $display("FAIL redirect_misaligned: pc=%h mis=%b, need 00000200/1", pc, misaligned);
    end
    redirect_valid = 1'b0;
    step();
    checks++;
    if (pc !== 32'h204 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL mis_pulse_end: pc=%h mis=%b, need 00000204/0", pc, misaligned);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (pc !== 32'hFFFF_FFFC || pcplus4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_top: pc=%h pcplus4=%h, need fffffffc/00000000", pc, pcplus4);
    end
    step();
    checks++;
    if (pc !== 32'h0 || pcplus4 !== 32'h4) begin
      errors++;
      $display("FAIL wrap_zero: pc=%h pcplus4=%h, need 00000000/00000004", pc, pcplus4);
    end
  endtask

  task automatic test_halt();
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0;
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    checks++;
    if (halted !== 1'b1 || pc_valid !== 1'b0 || pc !== 32'h40) begin
      errors++;
      $display("FAIL halt_enter: halted=%b valid=%b pc=%h, need 1/0/00000040", halted, pc_valid, pc);
    end
    redirect_valid = 1'b1;
    redirect_target = 32'h80;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (halted !== 1'b1 || pc_valid !== 1'b0 || pc !== 32'h80) begin
      errors++;
      $display("FAIL halt_redirect: halted=%b valid=%b pc=%h, need 1/0/00000080", halted, pc_valid, pc);
    end
    resume = 1'b1;
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    checks++;
    if (halted !== 1'b1 || pc_valid !== 1'b0) begin
      errors++;
      $display("FAIL resume_blocked: halted=%b valid=%b, need 1/0", halted, pc_valid);
    end
    step();
    resume = 1'b0;
    checks++;
    if (halted !== 1'b0 || pc_valid !== 1'b1 || pc !== 32'h80) begin
      errors++;
      $display("FAIL resume: halted=%b valid=%b pc=%h, need 0/1/00000080", halted, pc_valid, pc);
    end
    step();
    checks++;
    if (pc !== 32'h84) begin
      errors++;
      $display("FAIL post_resume: pc=%h, need 00000084", pc);
    end
  endtask

  task automatic test_reset_mid_halt();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pc !== 32'h0 || halted !== 1'b0 || pc_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pc=%h halted=%b valid=%b, need 00000000/0/0", pc, halted, pc_valid);
    end
`ifdef PC_FETCH_COUNTER_EN
    checks++;
    if (fetch_count !== 32'd0) begin
      errors++;
      $display("FAIL count_reset: count=%0d, need 0", fetch_count);
    end
`endif
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (pc !== 32'h14 || pc_valid !== 1'b1) begin
      errors++;
      $display("FAIL five_fires: pc=%h valid=%b, need 00000014/1", pc, pc_valid);
    end
`ifdef PC_FETCH_COUNTER_EN
    checks++;
    if (fetch_count !== 32'd5) begin
      errors++;
      $display("FAIL count_five: count=%0d, need 5", fetch_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stall();
    test_priority();
    test_wrap();
    test_halt();
    test_reset_mid_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer replacing the fixed 32-bit PC register at the front of the fetch stage. It holds the architectural fetch PC and supplies `pc`/`pcplus4` to instruction memory. It arbitrates trap, branch-redirect, stall and halt/resume requests by fixed priority, and advances only on a valid/ready handshake with fetch. An optional fetch counter is compiled in by macro.

## Interface
Parameters:
- `XLEN`, 32: PC width.
- `RESET_VECTOR`, 32'h0000_0000: PC loaded by reset; bits [1:0] must be 0.
- `CNT_WIDTH`, 32: fetch counter width. Used only with the macro.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fetch_ready` in 1: fetch accepts the current `pc` this cycle.
- `stall` in 1: hold the PC; suppresses increment only.
- `redirect_valid` in 1: branch/jump redirect request.
- `redirect_target` in XLEN: redirect address.
- `trap_valid` in 1: trap entry request.
- `trap_vector` in XLEN: trap handler address.
- `halt_req` in 1: request halt (debug).
- `resume` in 1: leave halt.
- `pc` out XLEN: current fetch address, registered.
- `pcplus4` out XLEN: `pc + 4`, combinational from `pc`.
- `pc_valid` out 1: `pc` is a valid fetch request.
- `halted` out 1: sequencer is in HALT.
- `misaligned` out 1: one-cycle pulse; the last redirect target had bits [1:0] ≠ 0.
- `fetch_count` out CNT_WIDTH: present only with the macro.

## Operation
- States: BOOT, RUN, HALT.
- Reset values: state BOOT, `pc` = RESET_VECTOR, `pc_valid` 0, `halted` 0, `misaligned` 0, `fetch_count` 0.
- BOOT: unconditionally goes to RUN on the next edge with `pc_valid` 1. All request inputs are ignored in BOOT.
- fire = `pc_valid & fetch_ready & ~stall`.
- RUN next-PC priority, highest first:
  1. `trap_valid`: `pc` ← {trap_vector[XLEN-1:2], 2'b00}.
  2. `redirect_valid`: `pc` ← {redirect_target[XLEN-1:2], 2'b00}; `misaligned` ← |redirect_target[1:0].
  3. fire: `pc` ← `pc + 4`.
  4. Otherwise `pc` holds.
- Trap and redirect are taken regardless of `stall` or `fetch_ready`. A cycle with trap or redirect is not a fire for counting.
- `halt_req` in RUN: go to HALT next edge; `pc_valid` ← 0, `halted` ← 1. A trap or redirect in the same cycle still updates `pc`; increment is suppressed.
- HALT:
  - `pc_valid` stays 0.
  - Trap and redirect still load `pc` and stay in HALT.
  - `resume & ~halt_req`: go to RUN; `pc_valid` ← 1, `halted` ← 0.
  - `resume & halt_req`: stay in HALT.
- Arithmetic: `pc + 4` is modulo 2^XLEN; 0xFFFF_FFFC wraps to 0x0000_0000. `pcplus4` wraps identically.
- `misaligned` deasserts on the next edge unless re-set. Trap vectors never raise it.
- Reset mid-operation: all state returns to reset values immediately, whatever state it is in.

## Timing
- All updates appear one cycle after the request edge. `pcplus4` follows `pc` in the same cycle.
- First valid fetch is one cycle after reset release (BOOT bubble).
- Redirect/trap to first valid target fetch: 1 cycle.
- Halt: `pc_valid` drops 1 cycle after `halt_req`.
- Resume: `pc_valid` rises 1 cycle after `resume`, at the held/updated `pc`.
- `misaligned` is registered and coincides with the loaded target on `pc`.

## Configuration
- `PC_FETCH_COUNTER_EN` defined:
  - `fetch_count` port and register exist.
  - Increments by 1 on each fire cycle without trap or redirect.
  - Wraps modulo 2^CNT_WIDTH; resets to 0.
- Undefined: port and logic are absent; all other behaviour is identical.

## Structure
- Package `pc_pkg`:
  - `pc_state_t` enum {PC_BOOT, PC_RUN, PC_HALT}.
  - localparam `PC_INCR` = 4.
  - default XLEN constant.
- One natural sub-module: `pc_next_sel`, the combinational priority mux producing next-PC and the misaligned flag. State register and counter stay in `pc_sequencer`.

## Test plan
- Reset release, `fetch_ready`=1, no requests → `pc_valid` 0 for one cycle, then `pc` = 0x0, 0x4, 0x8 on successive cycles.
- `stall`=1 for 3 cycles at `pc`=0x10 → `pc` holds 0x10; then 0x14 after stall drops. With `fetch_ready`=0 the PC also holds.
- Same cycle: `trap_valid` (vector 0x0000_0103) and `redirect_valid` (0x200) → `pc` = 0x100, `misaligned` 0. Redirect to 0x202 alone → `pc` = 0x200, `misaligned` pulses 1 for one cycle.
- `pc` = 0xFFFF_FFFC, fire → `pc` = 0x0, `pcplus4` = 0x4.
- `halt_req` at `pc`=0x40 → `halted` 1, `pc_valid` 0, `pc` 0x40. Redirect to 0x80 while halted → `pc` 0x80, still halted. `resume` → `pc_valid` 1 at 0x80.
- `rst` asserted mid-HALT → immediate return to RESET_VECTOR, BOOT, `halted` 0. With `PC_FETCH_COUNTER_EN`, 5 fires → `fetch_count` = 5, and 0 after reset.
